// File: rtl/seq_window_checker.sv
// Per-channel monitor for trig ##[MIN_DLY:MAX_DLY] resp with saturating match/fail counters.
// All outputs registered: a pulse appears the cycle after its deciding edge; no backpressure, channels never stall.
module seq_window_checker #(
  parameter int CHANNELS = 4,
  parameter int MIN_DLY  = 2,
  parameter int MAX_DLY  = 4,
  parameter int CNT_W    = 8
) (
  input  logic                      sysclk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      clr,
  input  logic [CHANNELS-1:0]       trig,
  input  logic [CHANNELS-1:0]       resp,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       match,
  output logic [CHANNELS-1:0]       fail,
  output logic [CHANNELS-1:0]       overlap,
  output logic [CHANNELS*CNT_W-1:0] match_cnt,
  output logic [CHANNELS*CNT_W-1:0] fail_cnt
);

  localparam int AW = $clog2(MAX_DLY + 1);
  localparam logic [AW-1:0]    MIN_A   = AW'(MIN_DLY);
  localparam logic [AW-1:0]    MAX_A   = AW'(MAX_DLY);
  localparam logic [AW-1:0]    ONE_A   = AW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_e           state_q, state_d;
    logic [AW-1:0]    age_q, age_d;
    logic             match_q, match_d;
    logic             fail_q, fail_d;
    logic             ovl_q, ovl_d, ovl_set;
    logic [CNT_W-1:0] mcnt_q, mcnt_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;

    always_comb begin
      state_d = state_q;
      age_d   = age_q;
      match_d = 1'b0;
      fail_d  = 1'b0;
      ovl_set = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (en && trig[i]) begin
            state_d = S_WAIT;
            age_d   = ONE_A;
          end
        end
        S_WAIT: begin
          if (!en) begin
            state_d = S_IDLE;
            age_d   = '0;
          end else if (resp[i] && (age_q >= MIN_A)) begin
            match_d = 1'b1;
          end else if (age_q == MAX_A) begin
            fail_d = 1'b1;
          end else begin
            age_d   = age_q + ONE_A;
            ovl_set = trig[i];
          end
          // A trig on the completing edge starts the next attempt immediately.
          if (match_d || fail_d) begin
            state_d = trig[i] ? S_WAIT : S_IDLE;
            age_d   = trig[i] ? ONE_A : '0;
          end
        end
        default: begin
          state_d = S_IDLE;
          age_d   = '0;
        end
      endcase
    end

    always_comb begin
      mcnt_d = mcnt_q;
      fcnt_d = fcnt_q;
      ovl_d  = ovl_q | ovl_set;
      if (clr) begin
        mcnt_d = '0;
        fcnt_d = '0;
        ovl_d  = 1'b0;
      end else begin
        if (match_d && (mcnt_q != CNT_MAX)) mcnt_d = mcnt_q + CNT_ONE;
        if (fail_d && (fcnt_q != CNT_MAX))  fcnt_d = fcnt_q + CNT_ONE;
      end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= S_IDLE;
        age_q   <= '0;
        match_q <= 1'b0;
        fail_q  <= 1'b0;
        ovl_q   <= 1'b0;
        mcnt_q  <= '0;
        fcnt_q  <= '0;
      end else begin
        state_q <= state_d;
        age_q   <= age_d;
        match_q <= match_d;
        fail_q  <= fail_d;
        ovl_q   <= ovl_d;
        mcnt_q  <= mcnt_d;
        fcnt_q  <= fcnt_d;
      end
    end

    assign busy[i]                      = (state_q == S_WAIT);
    assign match[i]                     = match_q;
    assign fail[i]                      = fail_q;
    assign overlap[i]                   = ovl_q;
    assign match_cnt[i*CNT_W +: CNT_W]  = mcnt_q;
    assign fail_cnt[i*CNT_W +: CNT_W]   = fcnt_q;
  end

endmodule
